// File: rtl/ngram_temporal_encoder.sv
// ngram_temporal_encoder
//   Builds the temporal query hypervector for the associative memory stage.
//   Each accepted sample is XOR-bound with rotated copies of the previous
//   NGRAM-1 samples to form an N-gram. WINDOW consecutive N-grams are then
//   bundled by per-bit majority into one registered output.
//
// Ports
//   Clk_CI, Reset_RI      clock (rising edge), async active-low reset
//   ValidIn_SI/ReadyOut_SO, HypervectorIn_DI    input sample handshake
//   ClearHistory_SI       sync flush of history, counters and pending output
//   ValidOut_SO/ReadyIn_SI, HypervectorOut_DO   bundled output handshake
//
// Bit 0 of every hypervector is the leftmost bit. rho^k moves bit i to
// bit (i+k) mod D.

`ifndef HV_DIMENSION
`define HV_DIMENSION 8
`endif

// Per-bit bundling counter. maj_o is the majority decision including the
// increment arriving this cycle, so the final N-gram of a window is counted
// on the same edge that registers the output.
module ngram_bit_counter #(
  parameter int WINDOW    = 5,
  parameter int CNT_WIDTH = 3
) (
  input  logic Clk_CI,
  input  logic Reset_RI,
  input  logic clr_i,
  input  logic inc_i,
  output logic maj_o
);
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, sum;

  always_comb begin
    sum   = cnt_q + CNT_WIDTH'(inc_i);
    // Strict greater-than: ties on even WINDOW resolve to 0.
    maj_o = {sum, 1'b0} > (CNT_WIDTH+1)'(WINDOW);
    cnt_d = clr_i ? '0 : sum;
  end

  always_ff @(posedge Clk_CI or negedge Reset_RI)
    if (!Reset_RI) cnt_q <= '0;
    else           cnt_q <= cnt_d;
endmodule

module ngram_temporal_encoder #(
  parameter int HV_DIMENSION = `HV_DIMENSION,
  parameter int NGRAM        = 3,
  parameter int WINDOW       = 5,
  parameter int CNT_WIDTH    = $clog2(WINDOW+1)
) (
  input  logic                  Clk_CI,
  input  logic                  Reset_RI,
  input  logic                  ValidIn_SI,
  output logic                  ReadyOut_SO,
  input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
  input  logic                  ClearHistory_SI,
  output logic                  ValidOut_SO,
  input  logic                  ReadyIn_SI,
  output logic [0:HV_DIMENSION-1] HypervectorOut_DO
);
  localparam int D = HV_DIMENSION;

  typedef enum logic {ACCUM = 1'b0, OUTPUT_STABLE = 1'b1} state_e;
  state_e state_q, state_d;

  logic                 accept, warm, produce, done;
  logic [0:D-1]         ngram, maj, hv_q, hv_d;
  logic [CNT_WIDTH-1:0] ngcnt_q, ngcnt_d;

  // ---------------- FSM ----------------
  always_ff @(posedge Clk_CI or negedge Reset_RI)
    if (!Reset_RI) state_q <= ACCUM;
    else           state_q <= state_d;

  always_comb begin
    state_d = state_q;
    if (ClearHistory_SI) state_d = ACCUM;
    else begin
      case (state_q)
        ACCUM:         if (done)       state_d = OUTPUT_STABLE;
        OUTPUT_STABLE: if (ReadyIn_SI) state_d = ACCUM;
        default:                       state_d = ACCUM;
      endcase
    end
  end

  // Ready is gated by reset and clear so nothing is accepted while flushing.
  always_comb begin
    ReadyOut_SO = Reset_RI && !ClearHistory_SI && (state_q == ACCUM);
    ValidOut_SO = (state_q == OUTPUT_STABLE);
  end

  assign accept  = ValidIn_SI && ReadyOut_SO;
  assign produce = accept && warm;
  assign done    = produce && (ngcnt_q == CNT_WIDTH'(WINDOW-1));

  // ---------------- history and N-gram ----------------
  generate
    if (NGRAM > 1) begin : g_hist
      localparam int FILL_W = $clog2(NGRAM);
      logic [NGRAM-2:0][0:D-1] hist_q, hist_d;
      logic [FILL_W-1:0]       fill_q, fill_d;

      // Warm once NGRAM-1 samples are in history; saturates there.
      assign warm = (fill_q == FILL_W'(NGRAM-1));

      always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (ClearHistory_SI) begin
          hist_d = '0;
          fill_d = '0;
        end else if (accept) begin
          hist_d[0] = HypervectorIn_DI;
          for (int j = 1; j < NGRAM-1; j++) hist_d[j] = hist_q[j-1];
          if (!warm) fill_d = fill_q + FILL_W'(1);
        end
        // H[k-1] is rotated by k before binding.
        ngram = HypervectorIn_DI;
        for (int k = 1; k < NGRAM; k++)
          for (int i = 0; i < D; i++)
            ngram[(i+k)%D] = ngram[(i+k)%D] ^ hist_q[k-1][i];
      end

      always_ff @(posedge Clk_CI or negedge Reset_RI)
        if (!Reset_RI) begin
          hist_q <= '0;
          fill_q <= '0;
        end else begin
          hist_q <= hist_d;
          fill_q <= fill_d;
        end
    end else begin : g_nohist
      assign warm  = 1'b1;
      assign ngram = HypervectorIn_DI;
    end
  endgenerate

  // ---------------- bundling ----------------
  genvar gi;
  generate
    for (gi = 0; gi < D; gi++) begin : g_bit
      ngram_bit_counter #(.WINDOW(WINDOW), .CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .Clk_CI   (Clk_CI),
        .Reset_RI (Reset_RI),
        .clr_i    (ClearHistory_SI || done),
        .inc_i    (produce && ngram[gi]),
        .maj_o    (maj[gi])
      );
    end
  endgenerate

  always_comb begin
    ngcnt_d = ngcnt_q;
    if (ClearHistory_SI || done) ngcnt_d = '0;
    else if (produce)            ngcnt_d = ngcnt_q + CNT_WIDTH'(1);
    // Output register survives clear; only a completed window reloads it.
    hv_d = done ? maj : hv_q;
  end

  always_ff @(posedge Clk_CI or negedge Reset_RI)
    if (!Reset_RI) begin
      ngcnt_q <= '0;
      hv_q    <= '0;
    end else begin
      ngcnt_q <= ngcnt_d;
      hv_q    <= hv_d;
    end

  assign HypervectorOut_DO = hv_q;
endmodule

// File: tb/tb_ngram_temporal_encoder.sv
// Directed bench for ngram_temporal_encoder. Four D=8 instances:
//   idx0 NGRAM=2 WINDOW=3, idx1 NGRAM=1 WINDOW=3,
//   idx2 NGRAM=3 WINDOW=1, idx3 NGRAM=1 WINDOW=2 (tie case).
// Inputs are driven at the falling edge; outputs are sampled there too.
module tb_ngram_temporal_encoder;
  logic       clk, rst_n;
  logic       vin  [4];
  logic       rdy  [4];
  logic [0:7] din  [4];
  logic       clr  [4];
  logic       vout [4];
  logic       rin  [4];
  logic [0:7] hv   [4];
  int cmp, errs;

  always #5 clk = ~clk;

  ngram_temporal_encoder #(.HV_DIMENSION(8), .NGRAM(2), .WINDOW(3)) u_n2w3 (
    .Clk_CI(clk), .Reset_RI(rst_n), .ValidIn_SI(vin[0]), .ReadyOut_SO(rdy[0]),
    .HypervectorIn_DI(din[0]), .ClearHistory_SI(clr[0]), .ValidOut_SO(vout[0]),
    .ReadyIn_SI(rin[0]), .HypervectorOut_DO(hv[0]));
  ngram_temporal_encoder #(.HV_DIMENSION(8), .NGRAM(1), .WINDOW(3)) u_n1w3 (
    .Clk_CI(clk), .Reset_RI(rst_n), .ValidIn_SI(vin[1]), .ReadyOut_SO(rdy[1]),
    .HypervectorIn_DI(din[1]), .ClearHistory_SI(clr[1]), .ValidOut_SO(vout[1]),
    .ReadyIn_SI(rin[1]), .HypervectorOut_DO(hv[1]));
  ngram_temporal_encoder #(.HV_DIMENSION(8), .NGRAM(3), .WINDOW(1)) u_n3w1 (
    .Clk_CI(clk), .Reset_RI(rst_n), .ValidIn_SI(vin[2]), .ReadyOut_SO(rdy[2]),
    .HypervectorIn_DI(din[2]), .ClearHistory_SI(clr[2]), .ValidOut_SO(vout[2]),
    .ReadyIn_SI(rin[2]), .HypervectorOut_DO(hv[2]));
  ngram_temporal_encoder #(.HV_DIMENSION(8), .NGRAM(1), .WINDOW(2)) u_n1w2 (
    .Clk_CI(clk), .Reset_RI(rst_n), .ValidIn_SI(vin[3]), .ReadyOut_SO(rdy[3]),
    .HypervectorIn_DI(din[3]), .ClearHistory_SI(clr[3]), .ValidOut_SO(vout[3]),
    .ReadyIn_SI(rin[3]), .HypervectorOut_DO(hv[3]));

  // One-cycle offer, entered and left at a falling edge.
  task automatic drive(input int k, input logic [7:0] d);
    vin[k] = 1'b1; din[k] = d;
    @(negedge clk);
    vin[k] = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    for (int k = 0; k < 4; k++) begin
      cmp++; if (rdy[k] !== 1'b0) begin errs++; $display("FAIL rst_rdy[%0d] got %b exp 0", k, rdy[k]); end
      cmp++; if (vout[k] !== 1'b0) begin errs++; $display("FAIL rst_vout[%0d] got %b exp 0", k, vout[k]); end
      cmp++; if (hv[k] !== 8'h00) begin errs++; $display("FAIL rst_hv[%0d] got %h exp 00", k, hv[k]); end
    end
    @(negedge clk); rst_n = 1'b1; #1;
    cmp++; if (rdy[0] !== 1'b1) begin errs++; $display("FAIL post_rst_rdy got %b exp 1", rdy[0]); end
    @(negedge clk);
  endtask

  task automatic test_warmup();
    rin[0] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      drive(0, 8'hF0);
      cmp++; if (vout[0] !== 1'b0) begin errs++; $display("FAIL warm_vout acc%0d got %b exp 0", n, vout[0]); end
    end
    drive(0, 8'hF0);
    cmp++; if (vout[0] !== 1'b1) begin errs++; $display("FAIL warm_vout4 got %b exp 1", vout[0]); end
    cmp++; if (hv[0] !== 8'h88) begin errs++; $display("FAIL warm_hv got %h exp 88", hv[0]); end
  endtask

  task automatic test_backpressure();
    vin[0] = 1'b1; din[0] = 8'h0F;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      cmp++; if (vout[0] !== 1'b1) begin errs++; $display("FAIL bp_vout c%0d got %b exp 1", n, vout[0]); end
      cmp++; if (hv[0] !== 8'h88) begin errs++; $display("FAIL bp_hv c%0d got %h exp 88", n, hv[0]); end
      cmp++; if (rdy[0] !== 1'b0) begin errs++; $display("FAIL bp_rdy c%0d got %b exp 0", n, rdy[0]); end
    end
    vin[0] = 1'b0; rin[0] = 1'b1;
    @(negedge clk);
    cmp++; if (vout[0] !== 1'b0) begin errs++; $display("FAIL bp_release_vout got %b exp 0", vout[0]); end
    cmp++; if (rdy[0] !== 1'b1) begin errs++; $display("FAIL bp_release_rdy got %b exp 1", rdy[0]); end
    // History must still be F0: N-grams 00, C3, FF -> majority C3.
    drive(0, 8'h78);
    drive(0, 8'hFF);
    cmp++; if (vout[0] !== 1'b0) begin errs++; $display("FAIL bp_resume_early got %b exp 0", vout[0]); end
    drive(0, 8'h00);
    cmp++; if (vout[0] !== 1'b1) begin errs++; $display("FAIL bp_resume_vout got %b exp 1", vout[0]); end
    cmp++; if (hv[0] !== 8'hC3) begin errs++; $display("FAIL bp_resume_hv got %h exp c3", hv[0]); end
  endtask

  task automatic test_majority();
    drive(1, 8'hF0); drive(1, 8'hCC);
    cmp++; if (vout[1] !== 1'b0) begin errs++; $display("FAIL maj_early got %b exp 0", vout[1]); end
    drive(1, 8'hAA);
    cmp++; if (vout[1] !== 1'b1) begin errs++; $display("FAIL maj1_vout got %b exp 1", vout[1]); end
    cmp++; if (hv[1] !== 8'hE8) begin errs++; $display("FAIL maj1_hv got %h exp e8", hv[1]); end
    tick();
    drive(1, 8'hFF); drive(1, 8'h00);
    cmp++; if (vout[1] !== 1'b0) begin errs++; $display("FAIL maj2_early got %b exp 0", vout[1]); end
    drive(1, 8'hFF);
    cmp++; if (hv[1] !== 8'hFF || vout[1] !== 1'b1) begin errs++; $display("FAIL maj2 got hv=%h v=%b exp ff/1", hv[1], vout[1]); end
    tick();
    drive(1, 8'h0F); drive(1, 8'h3C); drive(1, 8'hF0);
    cmp++; if (hv[1] !== 8'h3C || vout[1] !== 1'b1) begin errs++; $display("FAIL maj3 got hv=%h v=%b exp 3c/1", hv[1], vout[1]); end
  endtask

  task automatic test_rotation();
    drive(2, 8'h01);
    cmp++; if (vout[2] !== 1'b0) begin errs++; $display("FAIL rot_fill1 got %b exp 0", vout[2]); end
    drive(2, 8'h00);
    cmp++; if (vout[2] !== 1'b0) begin errs++; $display("FAIL rot_fill2 got %b exp 0", vout[2]); end
    drive(2, 8'h00);
    cmp++; if (hv[2] !== 8'h40 || vout[2] !== 1'b1) begin errs++; $display("FAIL rot_wrap got hv=%h v=%b exp 40/1", hv[2], vout[2]); end
    tick(); drive(2, 8'h00);
    cmp++; if (hv[2] !== 8'h00 || vout[2] !== 1'b1) begin errs++; $display("FAIL rot_aged got hv=%h v=%b exp 00/1", hv[2], vout[2]); end
    tick(); drive(2, 8'h80);
    cmp++; if (hv[2] !== 8'h80) begin errs++; $display("FAIL rot_k0 got %h exp 80", hv[2]); end
    tick(); drive(2, 8'h00);
    cmp++; if (hv[2] !== 8'h40) begin errs++; $display("FAIL rot_k1 got %h exp 40", hv[2]); end
    tick(); drive(2, 8'h00);
    cmp++; if (hv[2] !== 8'h20) begin errs++; $display("FAIL rot_k2 got %h exp 20", hv[2]); end
  endtask

  task automatic test_tie();
    drive(3, 8'hF0);
    cmp++; if (vout[3] !== 1'b0) begin errs++; $display("FAIL tie_early got %b exp 0", vout[3]); end
    drive(3, 8'hCC);
    cmp++; if (hv[3] !== 8'hC0 || vout[3] !== 1'b1) begin errs++; $display("FAIL tie got hv=%h v=%b exp c0/1", hv[3], vout[3]); end
  endtask

  task automatic test_clear();
    tick();
    drive(0, 8'h11);
    // Clear mid-window with a simultaneous offer.
    clr[0] = 1'b1; vin[0] = 1'b1; din[0] = 8'hFF; #1;
    cmp++; if (rdy[0] !== 1'b0) begin errs++; $display("FAIL clr_rdy got %b exp 0", rdy[0]); end
    @(negedge clk); clr[0] = 1'b0; vin[0] = 1'b0;
    cmp++; if (vout[0] !== 1'b0) begin errs++; $display("FAIL clr_mid_vout got %b exp 0", vout[0]); end
    cmp++; if (hv[0] !== 8'hC3) begin errs++; $display("FAIL clr_mid_hv got %h exp c3", hv[0]); end
    drive(0, 8'hF0); drive(0, 8'hF0); drive(0, 8'hF0);
    cmp++; if (vout[0] !== 1'b0) begin errs++; $display("FAIL clr_mid_warm got %b exp 0", vout[0]); end
    rin[0] = 1'b0;
    drive(0, 8'hF0);
    cmp++; if (hv[0] !== 8'h88 || vout[0] !== 1'b1) begin errs++; $display("FAIL clr_mid_out got hv=%h v=%b exp 88/1", hv[0], vout[0]); end
    // Clear while an output is pending.
    clr[0] = 1'b1; vin[0] = 1'b1; din[0] = 8'h0F;
    @(negedge clk); clr[0] = 1'b0; vin[0] = 1'b0;
    cmp++; if (vout[0] !== 1'b0) begin errs++; $display("FAIL clr_out_vout got %b exp 0", vout[0]); end
    cmp++; if (hv[0] !== 8'h88) begin errs++; $display("FAIL clr_out_hv got %h exp 88", hv[0]); end
    rin[0] = 1'b1;
    drive(0, 8'h0F); drive(0, 8'h0F); drive(0, 8'h0F);
    cmp++; if (vout[0] !== 1'b0) begin errs++; $display("FAIL clr_out_warm got %b exp 0", vout[0]); end
    drive(0, 8'h0F);
    cmp++; if (hv[0] !== 8'h88 || vout[0] !== 1'b1) begin errs++; $display("FAIL clr_out_next got hv=%h v=%b exp 88/1", hv[0], vout[0]); end
  endtask

  task automatic test_async_reset();
    tick();
    drive(0, 8'h0F); drive(0, 8'h0F);
    #2 rst_n = 1'b0; #1;
    cmp++; if (vout[0] !== 1'b0) begin errs++; $display("FAIL arst_vout got %b exp 0", vout[0]); end
    cmp++; if (hv[0] !== 8'h00) begin errs++; $display("FAIL arst_hv0 got %h exp 00", hv[0]); end
    cmp++; if (hv[1] !== 8'h00) begin errs++; $display("FAIL arst_hv1 got %h exp 00", hv[1]); end
    cmp++; if (rdy[0] !== 1'b0) begin errs++; $display("FAIL arst_rdy got %b exp 0", rdy[0]); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    drive(0, 8'hF0); drive(0, 8'hF0); drive(0, 8'hF0);
    cmp++; if (vout[0] !== 1'b0) begin errs++; $display("FAIL arst_warm got %b exp 0", vout[0]); end
    drive(0, 8'hF0);
    cmp++; if (hv[0] !== 8'h88 || vout[0] !== 1'b1) begin errs++; $display("FAIL arst_out got hv=%h v=%b exp 88/1", hv[0], vout[0]); end
  endtask

  initial begin
    cmp = 0; errs = 0;
    clk = 1'b0; rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vin[k] = 1'b0; din[k] = '0; clr[k] = 1'b0; rin[k] = 1'b1;
    end
    #1 rst_n = 1'b0;
    test_reset();
    test_warmup();
    test_backpressure();
    test_majority();
    test_rotation();
    test_tie();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
